// File: rtl/surf4_hk_pkg.sv
// Shared types and constants for the SURF4 housekeeping poller: FSM encoding,
// error markers written in place of failed reads, and trailer word layout.
package surf4_hk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_BUS   = 3'd2,
    ST_STORE = 3'd3,
    ST_TRAIL = 3'd4
  } hk_state_e;

  // Error marker for a slave-reported error; the low bits carry the entry index.
  localparam logic [31:0] DEAD_0000 = 32'hDEAD_0000;
  localparam logic [31:0] DEAD_FFFF = 32'hDEAD_FFFF;

  localparam int TBL_LAST_BIT = 20;

  localparam int TRL_SEQ_LSB = 16;
  localparam int TRL_ERR_LSB = 8;
  localparam int TRL_CNT_LSB = 0;

  function automatic logic [31:0] pack_trailer(input logic [15:0] seq,
                                               input logic [7:0]  errcnt,
                                               input logic [7:0]  count);
    logic [31:0] w;
    w = '0;
    w[TRL_SEQ_LSB +: 16] = seq;
    w[TRL_ERR_LSB +: 8]  = errcnt;
    w[TRL_CNT_LSB +: 8]  = count;
    return w;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/surf4_hk_addr_table.sv
// Poll address table: N_ENTRIES x {last, wb_addr[19:0]} distributed RAM with
// synchronous write and a registered, enabled read port.
module surf4_hk_addr_table #(
  parameter int N_ENTRIES = 16,
  parameter int AW        = $clog2(N_ENTRIES)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [20:0]   wdat_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [20:0]   rdat_o
);

  logic [20:0] mem [N_ENTRIES];

  // Contents are deliberately not reset so the array maps onto LUT RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdat_i;
  end

  // Read register holds between fetches so the bus address stays stable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdat_o <= '0;
    else if (re_i) rdat_o <= mem[raddr_i];
  end

endmodule

// File: rtl/surf4_hk_poller.sv
// Housekeeping poller: on each PPS rising edge, reads every table entry over
// WISHBONE and writes results plus a {seq, errcnt, count} trailer to the buffer.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for a PPS rising edge
// ST_FETCH | table read of entry idx in flight
// ST_BUS   | WB read cycle active; waiting for ack/err or timer expiry
// ST_STORE | result being written to buffer word idx; pick next entry
// ST_TRAIL | trailer being written to buffer word N_ENTRIES; bump seq
module surf4_hk_poller
  import surf4_hk_pkg::*;
#(
  parameter int N_ENTRIES = 16,
  parameter int TIMEOUT   = 255,
  localparam int AW       = $clog2(N_ENTRIES)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          pps_i,
  input  logic          tbl_we_i,
  input  logic [AW-1:0] tbl_addr_i,
  input  logic [20:0]   tbl_dat_i,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  output logic [19:0]   wbm_adr_o,
  output logic [31:0]   wbm_dat_o,
  output logic [3:0]    wbm_sel_o,
  input  logic [31:0]   wbm_dat_i,
  input  logic          wbm_ack_i,
  input  logic          wbm_err_i,
  output logic          buf_we_o,
  output logic [AW:0]   buf_addr_o,
  output logic [31:0]   buf_dat_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          overrun_o
);

  localparam logic [7:0]    TIMER_LOAD = 8'(TIMEOUT - 1);
  localparam logic [AW-1:0] IDX_MAX    = AW'(N_ENTRIES - 1);
  localparam logic [AW:0]   TRL_ADDR   = (AW + 1)'(N_ENTRIES);

  hk_state_e     state;
  logic [AW-1:0] idx;
  logic [15:0]   seq;
  logic [7:0]    errcnt;
  logic [7:0]    timer;
  logic          pps_q;
  logic          cyc_q;
  logic          buf_we_q;
  logic [AW:0]   buf_addr_q;
  logic [31:0]   buf_dat_q;
  logic          done_q;
  logic          overrun_q;
  logic [20:0]   entry;
  logic          entry_last;
  logic          pps_edge;
  logic          bus_end;

  assign pps_edge   = pps_i & ~pps_q;
  assign entry_last = entry[TBL_LAST_BIT];
  // Timer expiry is checked on the same cycle as ack/err, giving TIMEOUT BUS cycles.
  assign bus_end    = wbm_ack_i | wbm_err_i | (timer == 8'd0);

  surf4_hk_addr_table #(
    .N_ENTRIES (N_ENTRIES),
    .AW        (AW)
  ) u_table (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (tbl_we_i),
    .waddr_i (tbl_addr_i),
    .wdat_i  (tbl_dat_i),
    .re_i    (state == ST_FETCH),
    .raddr_i (idx),
    .rdat_o  (entry)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      idx        <= '0;
      seq        <= '0;
      errcnt     <= '0;
      timer      <= '0;
      pps_q      <= 1'b0;
      cyc_q      <= 1'b0;
      buf_we_q   <= 1'b0;
      buf_addr_q <= '0;
      buf_dat_q  <= '0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      pps_q    <= pps_i;
      buf_we_q <= 1'b0;
      done_q   <= 1'b0;
      if (pps_edge && (state != ST_IDLE)) overrun_q <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (pps_edge) begin
            idx    <= '0;
            errcnt <= '0;
            state  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          timer <= TIMER_LOAD;
          cyc_q <= 1'b1;
          state <= ST_BUS;
        end
        ST_BUS: begin
          if (bus_end) begin
            cyc_q      <= 1'b0;
            buf_we_q   <= 1'b1;
            buf_addr_q <= {1'b0, idx};
            state      <= ST_STORE;
            if (wbm_ack_i) begin
              buf_dat_q <= wbm_dat_i;
            end else if (wbm_err_i) begin
              buf_dat_q <= DEAD_0000 | 32'(idx);
              errcnt    <= sat_inc8(errcnt);
            end else begin
              buf_dat_q <= DEAD_FFFF;
              errcnt    <= sat_inc8(errcnt);
            end
          end else begin
            timer <= timer - 8'd1;
          end
        end
        ST_STORE: begin
          if (entry_last || (idx == IDX_MAX)) begin
            buf_we_q   <= 1'b1;
            buf_addr_q <= TRL_ADDR;
            buf_dat_q  <= pack_trailer(seq, errcnt, 8'(idx) + 8'd1);
            done_q     <= 1'b1;
            state      <= ST_TRAIL;
          end else begin
            idx   <= idx + 1'b1;
            state <= ST_FETCH;
          end
        end
        ST_TRAIL: begin
          seq   <= seq + 16'd1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = cyc_q;
  assign wbm_we_o   = 1'b0;
  assign wbm_adr_o  = entry[19:0];
  assign wbm_dat_o  = '0;
  assign wbm_sel_o  = cyc_q ? 4'hF : 4'h0;
  assign buf_we_o   = buf_we_q;
  assign buf_addr_o = buf_addr_q;
  assign buf_dat_o  = buf_dat_q;
  assign busy_o     = (state != ST_IDLE);
  assign done_o     = done_q;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_surf4_hk_poller.sv
// Directed bench for surf4_hk_poller with a behavioural WB slave and a buffer
// capture model; each check is an immediate assertion.
module tb_surf4_hk_poller;

  localparam int N  = 16;
  localparam int AW = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pps = 1'b0;
  logic          tbl_we = 1'b0;
  logic [AW-1:0] tbl_addr = '0;
  logic [20:0]   tbl_dat = '0;
  logic          cyc, stb, wbm_we;
  logic [19:0]   adr;
  logic [31:0]   wbm_wdat;
  logic [3:0]    sel;
  logic [31:0]   rdat = '0;
  logic          ack = 1'b0;
  logic          err = 1'b0;
  logic          buf_we;
  logic [AW:0]   buf_addr;
  logic [31:0]   buf_dat;
  logic          busy, done, overrun;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  surf4_hk_poller #(.N_ENTRIES(N), .TIMEOUT(TO)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .pps_i      (pps),
    .tbl_we_i   (tbl_we),
    .tbl_addr_i (tbl_addr),
    .tbl_dat_i  (tbl_dat),
    .wbm_cyc_o  (cyc),
    .wbm_stb_o  (stb),
    .wbm_we_o   (wbm_we),
    .wbm_adr_o  (adr),
    .wbm_dat_o  (wbm_wdat),
    .wbm_sel_o  (sel),
    .wbm_dat_i  (rdat),
    .wbm_ack_i  (ack),
    .wbm_err_i  (err),
    .buf_we_o   (buf_we),
    .buf_addr_o (buf_addr),
    .buf_dat_o  (buf_dat),
    .busy_o     (busy),
    .done_o     (done),
    .overrun_o  (overrun)
  );

  // Slave: responds on the third clock of a cycle; one address errors, one never answers.
  logic [19:0] err_adr   = 20'hFFFFF;
  logic [19:0] noack_adr = 20'hFFFFF;
  int          wait_cnt  = 0;

  function automatic logic [31:0] slave_data(input logic [19:0] a);
    case (a)
      20'h00400: return 32'h0000_0011;
      20'h00404: return 32'h0000_0022;
      20'h00408: return 32'h0000_0033;
      default:   return 32'hC000_0000 | {12'h000, a};
    endcase
  endfunction

  always @(posedge clk) begin
    ack <= 1'b0;
    err <= 1'b0;
    if (cyc && stb && !ack && !err) begin
      if (wait_cnt == 2) begin
        wait_cnt <= 0;
        if (adr == err_adr) err <= 1'b1;
        else if (adr != noack_adr) begin
          ack  <= 1'b1;
          rdat <= slave_data(adr);
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  // Buffer capture, done pulses and cyc run lengths, sampled 1ns after each edge.
  logic [31:0] bufmem [N+1];
  int n_wr = 0;
  int n_done = 0;
  int run = 0;
  int runs[$];

  always @(posedge clk) begin
    #1;
    if (buf_we) begin
      bufmem[buf_addr] = buf_dat;
      n_wr++;
    end
    if (done) n_done++;
    if (cyc) run++;
    else if (run > 0) begin
      runs.push_back(run);
      run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tbl_write(input int i, input logic [20:0] d);
    @(negedge clk);
    tbl_we   = 1'b1;
    tbl_addr = AW'(i);
    tbl_dat  = d;
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  task automatic pps_pulse();
    @(negedge clk);
    pps = 1'b1;
    @(negedge clk);
    pps = 1'b0;
  endtask

  task automatic clear_buf();
    for (int i = 0; i <= N; i++) bufmem[i] = 32'h5A5A_5A5A;
  endtask

  task automatic wait_done(input string tag);
    int start;
    int k;
    start = n_done;
    k = 0;
    while (n_done == start && k < 400) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done"}, 32'(n_done - start), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  int wr0;
  int dn0;
  int k;

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_cyc", {31'd0, cyc}, 32'd0);
    check("rst_sel", {28'd0, sel}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_bufwe", {31'd0, buf_we}, 32'd0);
    check("rst_done_ovr", {30'd0, done, overrun}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    tbl_write(0, {1'b0, 20'h00400});
    tbl_write(1, {1'b0, 20'h00404});
    tbl_write(2, {1'b1, 20'h00408});

    // 1: three-entry sweep, all acked
    clear_buf();
    wr0 = n_wr;
    pps_pulse();
    wait_done("t1");
    check("t1_b0", bufmem[0], 32'h0000_0011);
    check("t1_b1", bufmem[1], 32'h0000_0022);
    check("t1_b2", bufmem[2], 32'h0000_0033);
    check("t1_trl", bufmem[16], 32'h0000_0003);
    check("t1_nwr", 32'(n_wr - wr0), 32'd4);
    check("t1_busy", {31'd0, busy}, 32'd0);

    // 2: entry1 errors
    clear_buf();
    err_adr = 20'h00404;
    pps_pulse();
    wait_done("t2");
    err_adr = 20'hFFFFF;
    check("t2_b0", bufmem[0], 32'h0000_0011);
    check("t2_b1", bufmem[1], 32'hDEAD_0001);
    check("t2_b2", bufmem[2], 32'h0000_0033);
    check("t2_trl", bufmem[16], 32'h0001_0103);

    // 3: entry0 never acked, timeout after 8 BUS cycles
    clear_buf();
    noack_adr = 20'h00400;
    runs.delete();
    pps_pulse();
    wait_done("t3");
    noack_adr = 20'hFFFFF;
    check("t3_nruns", 32'(runs.size()), 32'd3);
    check("t3_cyc_to", 32'(runs[0]), 32'd8);
    check("t3_cyc_ack", 32'(runs[1]), 32'd4);
    check("t3_b0", bufmem[0], 32'hDEAD_FFFF);
    check("t3_b1", bufmem[1], 32'h0000_0022);
    check("t3_trl", bufmem[16], 32'h0002_0103);

    // 4: PPS while busy
    clear_buf();
    dn0 = n_done;
    check("t4_ovr_pre", {31'd0, overrun}, 32'd0);
    pps_pulse();
    repeat (4) @(negedge clk);
    pps_pulse();
    @(negedge clk);
    check("t4_ovr_set", {31'd0, overrun}, 32'd1);
    wait_done("t4");
    check("t4_trl", bufmem[16], 32'h0003_0003);
    repeat (40) @(negedge clk);
    check("t4_one_sweep", 32'(n_done - dn0), 32'd1);
    check("t4_idle", {31'd0, busy}, 32'd0);
    check("t4_ovr_held", {31'd0, overrun}, 32'd1);

    // 5: no last bit, full 16-entry sweep
    tbl_write(2, {1'b0, 20'h00408});
    for (int i = 3; i < N; i++) tbl_write(i, {1'b0, 20'h00400 + 20'(4 * i)});
    clear_buf();
    wr0 = n_wr;
    pps_pulse();
    wait_done("t5");
    check("t5_b3", bufmem[3], 32'hC000_040C);
    check("t5_b15", bufmem[15], 32'hC000_043C);
    check("t5_trl", bufmem[16], 32'h0004_0010);
    check("t5_nwr", 32'(n_wr - wr0), 32'd17);

    // 6: reset in the middle of a bus cycle
    wr0 = n_wr;
    pps_pulse();
    k = 0;
    while (!cyc && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t6_cyc_up", {31'd0, cyc}, 32'd1);
    check("t6_adr", {12'd0, adr}, 32'h0000_0400);
    check("t6_sel", {28'd0, sel}, 32'h0000_000F);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_cyc_stb", {30'd0, cyc, stb}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("t6_no_wr", 32'(n_wr - wr0), 32'd0);
    check("t6_ovr_clr", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    clear_buf();
    pps_pulse();
    wait_done("t6");
    check("t6_trl", bufmem[16], 32'h0000_0010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
